// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and the dump FSM state type for the
// parametrised register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;

    // Dump engine: idle, or streaming one register per accepted beat
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dump_state_e;

endpackage

// File: rtl/regfile_if.sv
// regfile_if: write/read/clear port and dump stream of the register file.
//   master: drives we/wa/wd/clear/ra1/ra2/dump_start/dump_ready
//   slave : drives rd1/rd2 (combinational) and the dump stream outputs
interface regfile_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              clear;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              dump_start;
    logic              dump_ready;
    logic              dump_valid;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_busy;

    modport master (
        output we, wa, wd, clear, ra1, ra2, dump_start, dump_ready,
        input  rd1, rd2, dump_valid, dump_addr, dump_data, dump_busy
    );

    modport slave (
        input  we, wa, wd, clear, ra1, ra2, dump_start, dump_ready,
        output rd1, rd2, dump_valid, dump_addr, dump_data, dump_busy
    );
endinterface

// File: rtl/regfile_dump_fsm.sv
// regfile_dump_fsm: walks an index over every register, presenting one
// beat per valid/ready transfer, then returns to IDLE.
//   clk, reset : clock, async active-low reset
//   i_start    : begin a dump (ignored while running)
//   i_ready    : consumer accepts the current beat
//   o_valid    : beat valid
//   o_busy     : dump in progress
//   o_addr     : index of the current beat
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_ready,
    output logic              o_valid,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    dump_state_e       r_state;
    dump_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;

    // State and index registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next state, index and decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        o_valid     = 1'b0;
        o_busy      = 1'b0;
        o_addr      = r_idx;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = RUN;
                    w_idx_nxt   = '0;
                end
            end
            RUN: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
                if (i_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + ADDR_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with one write port, two
// combinational read ports (optional write-through bypass), optional
// hardwired-zero register 0, synchronous clear and a handshaked dump stream.
//   clk, reset : clock, async active-low reset
//   bus        : regfile_if slave (write/clear/read ports and dump stream)
module regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    regfile_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_en;
    logic              w_dump_valid;
    logic [ADDR_W-1:0] w_dump_addr;

    // A write lands only when not overridden by clear and not aimed at a hardwired zero
    assign w_wr_en = bus.we && !bus.clear && !(ZERO_REG && (bus.wa == '0));

    // Storage array
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (bus.clear) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[bus.wa] <= bus.wd;
        end
    end

    // Read mux: zero register first, then same-cycle write forwarding
    function automatic logic [DATA_W-1:0] read_mux(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        if (ZERO_REG && (ra == '0))         return '0;
        if (BYPASS && wr_en && (wa == ra)) return wd;
        return stored;
    endfunction

    assign bus.rd1 = read_mux(bus.ra1, r_mem[bus.ra1], w_wr_en, bus.wa, bus.wd);
    assign bus.rd2 = read_mux(bus.ra2, r_mem[bus.ra2], w_wr_en, bus.wa, bus.wd);

    regfile_dump_fsm #(
        .ADDR_W (ADDR_W)
    ) u_dump (
        .clk     (clk),
        .reset   (reset),
        .i_start (bus.dump_start),
        .i_ready (bus.dump_ready),
        .o_valid (w_dump_valid),
        .o_busy  (bus.dump_busy),
        .o_addr  (w_dump_addr)
    );

    // Dump beats carry stored contents only; zeroed outside a dump
    assign bus.dump_valid = w_dump_valid;
    assign bus.dump_addr  = w_dump_addr;
    assign bus.dump_data  = (!w_dump_valid || (ZERO_REG && (w_dump_addr == '0)))
                            ? '0 : r_mem[w_dump_addr];

endmodule
